// File: rtl/instr_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit_pkg
// Description : Shared constants and state encoding for the fetch unit and CPU.
// Revision    : 1.0 - initial release
// ============================================================================
package instr_fetch_unit_pkg;

    localparam int         ADDR_W    = 8;
    localparam logic [7:0] NOP_INSTR = 8'hC0;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_LOAD  = 2'd1,
        ST_READY = 2'd2,
        ST_RUN   = 2'd3
    } ifu_state_t;

endpackage
`default_nettype wire

// File: rtl/instr_fetch_unit_ram.sv
`default_nettype none
// ============================================================================
// Module      : instr_ram
// Description : Instruction RAM, one synchronous write port, one async read port.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : Loads a program over a byte stream and feeds it to the CPU by pc.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int         ADDR_W    = instr_fetch_unit_pkg::ADDR_W,
    parameter logic [7:0] NOP_INSTR = instr_fetch_unit_pkg::NOP_INSTR
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_valid,
    input  logic [7:0]        load_data,
    input  logic              load_last,
    output logic              load_ready,
    input  logic              start,
    input  logic              stop,
    input  logic [ADDR_W-1:0] pc,
    output logic [7:0]        instruction,
    output logic              run_en,
    output logic              done,
    output logic [ADDR_W:0]   prog_len,
    output logic              load_err,
    output logic [1:0]        state
);

    localparam logic [ADDR_W:0] LAST_PTR = {1'b0, {ADDR_W{1'b1}}};
    localparam logic [ADDR_W:0] FULL_LEN = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE      = {{ADDR_W{1'b0}}, 1'b1};

    ifu_state_t          cur_state;
    logic [ADDR_W:0]     wr_ptr;
    logic                accept;
    logic [ADDR_W-1:0]   waddr;
    logic [7:0]          rdata;
    logic                in_range;

    assign load_ready = (cur_state != ST_RUN);
    assign accept     = load_valid && load_ready;
    // Any accept outside LOAD begins a fresh program at address 0.
    assign waddr      = (cur_state == ST_LOAD) ? wr_ptr[ADDR_W-1:0] : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_state <= ST_EMPTY;
            wr_ptr    <= '0;
            prog_len  <= '0;
            load_err  <= 1'b0;
        end else begin
            case (cur_state)
                ST_EMPTY, ST_READY: begin
                    if (accept) begin
                        wr_ptr   <= ONE;
                        load_err <= 1'b0;
                        if (load_last) begin
                            prog_len  <= ONE;
                            cur_state <= ST_READY;
                        end else begin
                            prog_len  <= '0;
                            cur_state <= ST_LOAD;
                        end
                    end else if (start && cur_state == ST_READY) begin
                        cur_state <= ST_RUN;
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        wr_ptr <= wr_ptr + ONE;
                        if (load_last) begin
                            prog_len  <= wr_ptr + ONE;
                            cur_state <= ST_READY;
                        end else if (wr_ptr == LAST_PTR) begin
                            prog_len  <= FULL_LEN;
                            load_err  <= 1'b1;
                            cur_state <= ST_READY;
                        end
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        cur_state <= ST_READY;
                    end
                end
                default: cur_state <= ST_EMPTY;
            endcase
        end
    end

    instr_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (8)
    ) u_ram (
        .clk   (clk),
        .we    (accept),
        .waddr (waddr),
        .wdata (load_data),
        .raddr (pc),
        .rdata (rdata)
    );

    // 9-bit compare so a full 256-byte program never reports done.
    assign in_range    = ({1'b0, pc} < prog_len);
    assign run_en      = (cur_state == ST_RUN);
    assign done        = run_en && !in_range;
    assign instruction = (run_en && in_range) ? rdata : NOP_INSTR;
    assign state       = cur_state;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Directed self-checking bench with a fetch scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       load_valid;
    logic [7:0] load_data;
    logic       load_last;
    logic       load_ready;
    logic       start;
    logic       stop;
    logic [7:0] pc;
    logic [7:0] instruction;
    logic       run_en;
    logic       done;
    logic [8:0] prog_len;
    logic       load_err;
    logic [1:0] state;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] pc;
        logic [7:0] instr;
        logic       done;
    } fetch_exp_t;

    fetch_exp_t sb[$];
    logic [7:0] model [256];

    instr_fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_last   (load_last),
        .load_ready  (load_ready),
        .start       (start),
        .stop        (stop),
        .pc          (pc),
        .instruction (instruction),
        .run_en      (run_en),
        .done        (done),
        .prog_len    (prog_len),
        .load_err    (load_err),
        .state       (state)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are then stable.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_byte(input logic [7:0] d, input logic last);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        step();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic expect_fetch(input logic [7:0] p, input logic [7:0] ins, input logic dn);
        fetch_exp_t e;
        e.pc = p; e.instr = ins; e.done = dn;
        sb.push_back(e);
    endtask

    task automatic drain_fetch(input string tag);
        fetch_exp_t e;
        while (sb.size() > 0) begin
            e  = sb.pop_front();
            pc = e.pc;
            #1;
            check({tag, "_instr"}, {8'h0, instruction}, {8'h0, e.instr});
            check({tag, "_done"},  {15'h0, done},       {15'h0, e.done});
        end
    endtask

    initial begin
        reset = 1'b1; load_valid = 1'b0; load_data = '0; load_last = 1'b0;
        start = 1'b0; stop = 1'b0; pc = '0;
        step(); step();
        check("rst_state",  {14'h0, state},      16'd0);
        check("rst_ready",  {15'h0, load_ready}, 16'd1);
        check("rst_run_en", {15'h0, run_en},     16'd0);
        check("rst_done",   {15'h0, done},       16'd0);
        check("rst_instr",  {8'h0, instruction}, 16'h00C0);
        check("rst_len",    {7'h0, prog_len},    16'd0);
        check("rst_err",    {15'h0, load_err},   16'd0);
        reset = 1'b0;
        step();

        // 1: three-byte program then run
        load_byte(8'h05, 1'b0);
        check("t1_state_load", {14'h0, state}, 16'd1);
        load_byte(8'h46, 1'b0);
        load_byte(8'h89, 1'b1);
        check("t1_state_ready", {14'h0, state},   16'd2);
        check("t1_len",         {7'h0, prog_len}, 16'd3);
        pulse_start();
        check("t1_run_en", {15'h0, run_en}, 16'd1);
        expect_fetch(8'd0, 8'h05, 1'b0);
        expect_fetch(8'd1, 8'h46, 1'b0);
        expect_fetch(8'd2, 8'h89, 1'b0);
        expect_fetch(8'd3, 8'hC0, 1'b1);
        drain_fetch("t1");
        pulse_stop();
        check("t1_stop", {14'h0, state}, 16'd2);

        // 2: 256 bytes without load_last
        for (int i = 0; i < 256; i++) begin
            model[i] = 8'((i * 7 + 3) & 8'hFF);
            load_byte(model[i], 1'b0);
            if (i == 254) check("t2_still_load", {14'h0, state}, 16'd1);
        end
        check("t2_state", {14'h0, state},    16'd2);
        check("t2_len",   {7'h0, prog_len},  16'd256);
        check("t2_err",   {15'h0, load_err}, 16'd1);
        pulse_start();
        expect_fetch(8'd255, model[255], 1'b0);
        expect_fetch(8'd0,   model[0],   1'b0);
        expect_fetch(8'd128, model[128], 1'b0);
        drain_fetch("t2");

        // 3: load attempts in RUN are ignored
        load_valid = 1'b1; load_data = 8'hFF; load_last = 1'b1;
        #1;
        check("t3_ready", {15'h0, load_ready}, 16'd0);
        step(); step();
        load_valid = 1'b0; load_last = 1'b0;
        check("t3_state", {14'h0, state}, 16'd3);
        expect_fetch(8'd0, model[0], 1'b0);
        drain_fetch("t3");
        pulse_stop();
        check("t3_stop", {14'h0, state}, 16'd2);
        load_byte(8'hAA, 1'b0);
        check("t3_reload_state", {14'h0, state},    16'd1);
        check("t3_reload_len",   {7'h0, prog_len},  16'd0);
        check("t3_reload_err",   {15'h0, load_err}, 16'd0);
        load_byte(8'hBB, 1'b1);
        check("t3_len2", {7'h0, prog_len}, 16'd2);
        pulse_start();
        expect_fetch(8'd0, 8'hAA, 1'b0);
        expect_fetch(8'd1, 8'hBB, 1'b0);
        expect_fetch(8'd2, 8'hC0, 1'b1);
        drain_fetch("t3r");
        pulse_stop();

        // 4: accept and start together, load wins
        load_valid = 1'b1; load_data = 8'h12; load_last = 1'b1; start = 1'b1;
        step();
        load_valid = 1'b0; load_last = 1'b0; start = 1'b0;
        check("t4_state",  {14'h0, state},   16'd2);
        check("t4_len",    {7'h0, prog_len}, 16'd1);
        check("t4_run_en", {15'h0, run_en},  16'd0);
        pulse_start();
        check("t4_run", {14'h0, state}, 16'd3);
        expect_fetch(8'd0, 8'h12, 1'b0);
        expect_fetch(8'd1, 8'hC0, 1'b1);
        drain_fetch("t4");
        pulse_stop();

        // 5: asynchronous reset mid-load
        load_byte(8'h21, 1'b0);
        load_byte(8'h22, 1'b0);
        check("t5_load", {14'h0, state}, 16'd1);
        #2 reset = 1'b1;
        #1;
        check("t5_async_state", {14'h0, state},      16'd0);
        check("t5_async_len",   {7'h0, prog_len},    16'd0);
        check("t5_async_ready", {15'h0, load_ready}, 16'd1);
        step();
        reset = 1'b0;
        step();
        pulse_start();
        pc = 8'd0;
        #1;
        check("t5_start_ign", {14'h0, state},      16'd0);
        check("t5_instr",     {8'h0, instruction}, 16'h00C0);

        // 6: start/stop ignored in EMPTY and LOAD
        pulse_stop();
        check("t6_empty_stop", {14'h0, state}, 16'd0);
        load_byte(8'h33, 1'b0);
        pulse_start();
        check("t6_load_start", {14'h0, state},      16'd1);
        check("t6_run_en",     {15'h0, run_en},     16'd0);
        check("t6_instr",      {8'h0, instruction}, 16'h00C0);
        pulse_stop();
        check("t6_load_stop", {14'h0, state}, 16'd1);
        load_byte(8'h44, 1'b1);
        check("t6_len", {7'h0, prog_len}, 16'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
